// File: rtl/dt_pack.sv
// Streams the distance map out of the result RAM, thresholds each pixel and packs
// 16 binary pixels MSB-first per word into the packed-image memory, with side statistics.
module dt_pack #(
  parameter int DIST_W  = 8,
  parameter int N_WORDS = 1024,
  localparam int PIX_W  = $clog2(N_WORDS * 16),
  localparam int WORD_W = $clog2(N_WORDS),
  localparam int CNT_W  = PIX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIST_W-1:0] thr,
  output logic              res_rd,
  output logic [PIX_W-1:0]  res_addr,
  input  logic [DIST_W-1:0] res_di,
  output logic              pk_wr,
  output logic [WORD_W-1:0] pk_addr,
  output logic [15:0]       pk_do,
  output logic              busy,
  output logic              done,
  output logic [DIST_W-1:0] max_dist,
  output logic [CNT_W-1:0]  obj_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_WORDS * 16 - 1);

  state_t              state, state_next;
  logic [DIST_W-1:0]   thr_q;
  logic                rd_q;
  logic [15:0]         sr;
  logic [3:0]          bit_cnt;
  logic [WORD_W-1:0]   word_cnt;
  logic                accept;
  logic                hit;

  assign accept = start && (state == IDLE || state == DONE);
  assign hit    = (res_di >= thr_q);
  assign res_rd = (state == RUN);
  assign busy   = (state == RUN) || (state == FLUSH);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FLUSH only waits for the final word's write pulse, which is the single pk_wr seen there
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN:        if (res_addr == LAST_PIX) state_next = FLUSH;
      FLUSH:      if (pk_wr) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // rd_q marks cycles where res_di carries the pixel addressed one cycle earlier
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q    <= '0;
      rd_q     <= 1'b0;
      sr       <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      res_addr <= '0;
      pk_wr    <= 1'b0;
      pk_addr  <= '0;
      pk_do    <= '0;
      max_dist <= '0;
      obj_cnt  <= '0;
    end else begin
      pk_wr <= 1'b0;
      rd_q  <= res_rd;
      if (accept) begin
        thr_q    <= thr;
        sr       <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        res_addr <= '0;
        max_dist <= '0;
        obj_cnt  <= '0;
      end else begin
        if (res_rd) res_addr <= res_addr + 1'b1;
        if (rd_q) begin
          sr      <= {sr[14:0], hit};
          bit_cnt <= bit_cnt + 1'b1;
          if (res_di > max_dist) max_dist <= res_di;
          if (res_di != '0) obj_cnt <= obj_cnt + 1'b1;
          if (bit_cnt == 4'hF) begin
            pk_wr    <= 1'b1;
            pk_addr  <= word_cnt;
            pk_do    <= {sr[14:0], hit};
            word_cnt <= word_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/dt_pack.md
Name: dt_pack

Overview:
- Reads the 128x128 8-bit distance map from the result RAM (res bus) after the distance-transform pass completes.
- Thresholds each pixel and packs 16 binary pixels MSB-first into one 16-bit word, writing 1024 words to a packed-image memory (pk bus). This is the inverse of the bit-unpacking load path.
- Collects max distance and object-pixel count as side statistics.
- Owns the res bus only while busy. res_rd is 0 otherwise, so the bus can be shared with the transform block.

Parameters:
- DIST_W, 8, width of one distance pixel on res_di and thr.
- N_WORDS, 1024, number of packed words (pixels = 16*N_WORDS = 16384; res_addr 14 bits, pk_addr 10 bits).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a pass; sampled in IDLE or DONE.
- thr  input  8  threshold; sampled when start is accepted.
- res_rd  output  1  RAM read strobe.
- res_addr  output  14  RAM pixel address.
- res_di  input  8  RAM read data, valid the cycle after res_rd.
- pk_wr  output  1  packed-memory write strobe.
- pk_addr  output  10  packed word address.
- pk_do  output  16  packed word data.
- busy  output  1  high in RUN/FLUSH.
- done  output  1  high in DONE.
- max_dist  output  8  maximum res_di over the pass.
- obj_cnt  output  15  count of pixels with res_di != 0.

Behaviour:
- Reset (clk edge with reset=1): state IDLE; every output 0, including res_addr, pk_addr, pk_do, max_dist, obj_cnt. Internal shift register and counters are cleared.
- Reset mid-pass: aborts immediately. No pk_wr after the reset edge. Memory contents already written are left as is.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on start=1.
- DONE -> RUN on start=1. Otherwise DONE holds, with done=1 and statistics stable.
- On start acceptance (edge E0): latch thr; clear max_dist, obj_cnt, shift register, word counter; res_addr=0.
- Cycle numbering: cycle n is the cycle after edge E(n-1), so cycle 1 follows E0.
- RUN, read issue: res_rd=1 every cycle. Pixel p is addressed in cycle 1+p; res_addr increments by 1 each cycle.
- RUN -> FLUSH after address 16383 is issued, i.e. at the end of cycle 16384. res_rd=0 in FLUSH.
- Capture: res_di for pixel p is valid in cycle 2+p. At the end of that cycle:
  - shift register <= {sr[14:0], (res_di >= thr_latched)} (unsigned compare);
  - max_dist <= max(max_dist, res_di);
  - obj_cnt += (res_di != 0).
- Packing order: pixel p maps to word p>>4, bit 15-(p&15). The first pixel of a word lands in bit 15.
- Write: word k completes at the end of cycle 17+16k. In cycle 18+16k, pk_wr=1, pk_addr=k, pk_do=word. pk_wr is a single-cycle pulse; reads are never stalled.
- First write is in cycle 18; last write (k=1023) is in cycle 16386.
- FLUSH -> DONE after the last write. done=1 from cycle 16387.
- thr=0: every pixel packs to 1.
- thr=255: only pixels with res_di=255 pack to 1.
- start while busy: ignored.
- obj_cnt cannot overflow: 15 bits, max 16384.
- res_addr wraps 16383 -> 0 internally, but res_rd is already 0 by then.

Test Plan:
- All-zero RAM, thr=1 -> 1024 pk_wr pulses of 0x0000 at pk_addr 0..1023 in order; max_dist=0; obj_cnt=0; done first high at cycle 16387.
- RAM zero except pixel 129 = 1, thr=1 -> word 8 = 0x4000, all other words 0x0000; max_dist=1; obj_cnt=1.
- RAM ramp (value = addr[7:0]), thr=128 -> words with (k&15)>=8 = 0xFFFF, others 0x0000; max_dist=255; obj_cnt=16320.
- Any map, thr=0 -> every word 0xFFFF.
- Timing: res_rd high cycles 1..16384 with res_addr = cycle-1; first pk_wr at cycle 18 (pk_addr 0); a start pulse at cycle 100 has no effect.
- reset=1 at cycle 5000 -> no pk_wr afterwards; done=0; all outputs 0. Then start with thr=1 on the all-zero map -> full correct pass from pk_addr 0.
